// File: rtl/card_dealer_if.sv
// Card dealer bus: draw/shuffle requests in, dealt card and deck status out.
interface card_dealer_if #(
    parameter int CARD_W = 6,
    parameter int RAND_W = 8
);
    logic [RAND_W-1:0] rand_in;
    logic              draw_req;
    logic              shuffle;
    logic [CARD_W-1:0] card_out;
    logic              card_valid;
    logic              busy;
    logic              draw_err;
    logic [CARD_W:0]   remaining;
    logic              deck_empty;

    // Requester side: drives requests and random source, observes the deck
    modport master (
        output rand_in, draw_req, shuffle,
        input  card_out, card_valid, busy, draw_err, remaining, deck_empty
    );

    // Dealer side
    modport slave (
        input  rand_in, draw_req, shuffle,
        output card_out, card_valid, busy, draw_err, remaining, deck_empty
    );
endinterface

// File: rtl/card_dealer.sv
// Card dealer: deals each card of a deck at most once between shuffles.
// A draw starts at a random index and probes forward, wrapping, until it
// finds an undealt card; shuffle returns every card to the deck.
module card_dealer #(
    parameter int NUM_CARDS = 52,
    parameter int CARD_W    = 6,
    parameter int RAND_W    = 8
) (
    input logic          clk,
    input logic          reset_n,
    card_dealer_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } state_t;

    localparam logic [RAND_W-1:0] NUM_R      = RAND_W'(NUM_CARDS);
    localparam logic [CARD_W-1:0] LAST_IDX   = CARD_W'(NUM_CARDS - 1);
    localparam logic [CARD_W:0]   FULL_COUNT = (CARD_W + 1)'(NUM_CARDS);

    state_t                 state;
    state_t                 next_state;
    logic [NUM_CARDS-1:0]   dealt;
    logic [CARD_W-1:0]      idx;
    logic [CARD_W-1:0]      card_q;
    logic                   valid_q;
    logic                   err_q;
    logic [CARD_W:0]        remaining_q;
    logic                   has_cards;
    logic                   accept_draw;
    logic                   probe_hit;

    assign has_cards   = (remaining_q != '0);
    assign accept_draw = bus.draw_req && !bus.shuffle && has_cards;
    assign probe_hit   = !dealt[idx];

    // State register; reset abandons any draw in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: shuffle always returns to IDLE, a hit ends the probe
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept_draw) begin
                    next_state = PROBE;
                end
            end
            PROBE: begin
                if (bus.shuffle || probe_hit) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Deck bookkeeping, probe index and registered result pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dealt       <= '0;
            idx         <= '0;
            card_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            remaining_q <= FULL_COUNT;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.shuffle) begin
                        dealt       <= '0;
                        remaining_q <= FULL_COUNT;
                    end else if (bus.draw_req) begin
                        if (has_cards) begin
                            idx <= CARD_W'(bus.rand_in % NUM_R);
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                PROBE: begin
                    if (bus.shuffle) begin
                        dealt       <= '0;
                        remaining_q <= FULL_COUNT;
                    end else if (probe_hit) begin
                        dealt[idx]  <= 1'b1;
                        card_q      <= idx;
                        valid_q     <= 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                    end else begin
                        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: busy tracks the probe state, deck_empty follows the count
    always_comb begin
        bus.busy       = (state == PROBE);
        bus.deck_empty = (remaining_q == '0);
        bus.card_out   = card_q;
        bus.card_valid = valid_q;
        bus.draw_err   = err_q;
        bus.remaining  = remaining_q;
    end
endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: a deck model predicts each dealt card,
// its arrival cycle and the remaining count; a monitor pops and compares.
module tb_card_dealer;
    localparam int NUM_CARDS = 52;
    localparam int CARD_W    = 6;
    localparam int RAND_W    = 8;

    typedef struct {
        bit is_err;
        int card;
        int rem;
        int cyc;
    } expect_t;

    logic clk = 1'b0;
    logic reset_n;

    card_dealer_if #(.CARD_W(CARD_W), .RAND_W(RAND_W)) bus ();

    card_dealer #(
        .NUM_CARDS(NUM_CARDS),
        .CARD_W   (CARD_W),
        .RAND_W   (RAND_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    expect_t score_q[$];
    int      errors      = 0;
    int      checks      = 0;
    int      cycle_count = 0;
    bit      dealt_m[NUM_CARDS];
    int      rem_m;
    int      busy_left_m;
    int      last_card_m;
    int      pending_card_m;

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle_count);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < NUM_CARDS; i++) dealt_m[i] = 1'b0;
        rem_m = NUM_CARDS;
    endtask

    task automatic modelReset();
        modelClear();
        busy_left_m = 0;
        last_card_m = 0;
        score_q.delete();
    endtask

    task automatic modelStep(input bit draw, input bit shuf, input int r);
        int start;
        int k;
        int card;
        expect_t e;
        if (!reset_n) begin
            modelReset();
        end else if (busy_left_m > 0) begin
            if (shuf) begin
                if (score_q.size() > 0) void'(score_q.pop_back());
                modelClear();
                busy_left_m = 0;
            end else begin
                busy_left_m--;
                if (busy_left_m == 0) last_card_m = pending_card_m;
            end
        end else if (shuf) begin
            modelClear();
        end else if (draw) begin
            if (rem_m == 0) begin
                e.is_err = 1'b1;
                e.card   = last_card_m;
                e.rem    = 0;
                e.cyc    = cycle_count;
                score_q.push_back(e);
            end else begin
                start = r % NUM_CARDS;
                k = 0;
                while (dealt_m[(start + k) % NUM_CARDS]) k++;
                card = (start + k) % NUM_CARDS;
                dealt_m[card] = 1'b1;
                rem_m--;
                pending_card_m = card;
                busy_left_m = k + 1;
                e.is_err = 1'b0;
                e.card   = card;
                e.rem    = rem_m;
                e.cyc    = cycle_count + k + 1;
                score_q.push_back(e);
            end
        end
    endtask

    task automatic applyStimulus(input bit draw, input bit shuf, input int r);
        logic [RAND_W-1:0] rv;
        rv = RAND_W'(r);
        bus.draw_req = draw;
        bus.shuffle  = shuf;
        bus.rand_in  = rv;
        @(posedge clk);
        #1;
        cycle_count++;
        modelStep(draw, shuf, int'(rv));
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (busy_left_m > 0 && guard < 200) begin
            applyStimulus(1'b0, 1'b0, 0);
            guard++;
        end
        applyStimulus(1'b0, 1'b0, 0);
    endtask

    // Monitor: every card_valid or draw_err pulse must match the next prediction
    always @(negedge clk) begin : monitor
        expect_t e;
        if (reset_n && (bus.card_valid || bus.draw_err)) begin
            if (score_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: card_valid=%0b draw_err=%0b, required none (cycle %0d)",
                         bus.card_valid, bus.draw_err, cycle_count);
            end else begin
                e = score_q.pop_front();
                checkOutput("valid_err_exclusive", int'(bus.card_valid && bus.draw_err), 0);
                checkOutput("event_is_err", int'(bus.draw_err), int'(e.is_err));
                checkOutput("card_out", int'(bus.card_out), e.card);
                checkOutput("remaining", int'(bus.remaining), e.rem);
                checkOutput("deck_empty", int'(bus.deck_empty), int'(e.rem == 0));
                checkOutput("event_cycle", cycle_count, e.cyc);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios followed by a randomized run
    initial begin
        reset_n      = 1'b0;
        bus.draw_req = 1'b0;
        bus.shuffle  = 1'b0;
        bus.rand_in  = '0;
        modelReset();
        pending_card_m = 0;

        // Reset state
        applyStimulus(1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 0);
        #2 reset_n = 1'b1;
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_card_valid", int'(bus.card_valid), 0);
        checkOutput("reset_draw_err", int'(bus.draw_err), 0);
        checkOutput("reset_remaining", int'(bus.remaining), NUM_CARDS);
        checkOutput("reset_card_out", int'(bus.card_out), 0);
        checkOutput("reset_deck_empty", int'(bus.deck_empty), 0);

        // First draw straight out of reset
        applyStimulus(1'b1, 1'b0, 10);
        checkOutput("busy_after_accept", int'(bus.busy), 1);
        waitIdle();
        checkOutput("first_card", int'(bus.card_out), 10);
        checkOutput("first_remaining", int'(bus.remaining), 51);

        // Probe wraps from the last card back to card 0
        applyStimulus(1'b0, 1'b1, 0);
        applyStimulus(1'b1, 1'b0, 51);
        waitIdle();
        applyStimulus(1'b1, 1'b0, 51);
        waitIdle();
        checkOutput("wrap_card", int'(bus.card_out), 0);

        // Random input above the deck size is reduced modulo NUM_CARDS
        applyStimulus(1'b0, 1'b1, 0);
        applyStimulus(1'b1, 1'b0, 200);
        waitIdle();
        checkOutput("modulo_card", int'(bus.card_out), 44);
        checkOutput("shuffle_then_draw_remaining", int'(bus.remaining), 51);

        // Hold draw_req high until the deck runs out, then one more request
        applyStimulus(1'b0, 1'b1, 0);
        for (int guard = 0; guard < 4000 && (rem_m > 0 || busy_left_m > 0); guard++) begin
            applyStimulus(1'b1, 1'b0, int'($urandom));
        end
        applyStimulus(1'b1, 1'b0, int'($urandom));
        applyStimulus(1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("empty_deck_empty", int'(bus.deck_empty), 1);
        checkOutput("empty_remaining", int'(bus.remaining), 0);

        // Shuffle on the third probe cycle aborts the draw
        applyStimulus(1'b0, 1'b1, 0);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, 1'b0, i);
            waitIdle();
        end
        applyStimulus(1'b1, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 0);
        checkOutput("abort_busy", int'(bus.busy), 0);
        checkOutput("abort_remaining", int'(bus.remaining), NUM_CARDS);
        checkOutput("abort_card_valid", int'(bus.card_valid), 0);
        applyStimulus(1'b0, 1'b0, 0);

        // Asynchronous reset in the middle of a long probe
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, i);
            waitIdle();
        end
        applyStimulus(1'b1, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("pre_reset_busy", int'(bus.busy), 1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("async_reset_busy", int'(bus.busy), 0);
        checkOutput("async_reset_remaining", int'(bus.remaining), NUM_CARDS);
        checkOutput("async_reset_card_out", int'(bus.card_out), 0);
        checkOutput("async_reset_card_valid", int'(bus.card_valid), 0);
        modelReset();
        #1 reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 5);
        waitIdle();
        checkOutput("post_reset_card", int'(bus.card_out), 5);

        // Randomized traffic with occasional shuffles
        for (int n = 0; n < 1500; n++) begin
            bit d;
            bit s;
            d = ($urandom_range(0, 9) < 6);
            s = ($urandom_range(0, 99) < 3) || (rem_m == 0 && $urandom_range(0, 9) < 3);
            applyStimulus(d, s, int'($urandom));
        end
        waitIdle();
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("scoreboard_drained", score_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
